turf_bus_initiator: RTL

- TURFIO-side master for the TURF register bus (nCSTURF / TURF_WnR / TURF_DIO[7:0]); the opposite end of the TURF register responder.
- Converts single-word local requests (8-bit address, 32-bit data) into byte-serial bus transactions.
- Sits in TURFIO firmware between the host-command decoder and the tristate DIO pads; pads are instantiated at top level.

---
 rtl/turf_bus_pkg.sv | 32 +++
 rtl/turf_bus_initiator.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/turf_bus_pkg.sv
// ----------------------------------------------------------------------------
// turf_bus_pkg
// Shared definitions for both ends of the TURF register bus
// (nCSTURF / TURF_WnR / TURF_DIO[7:0]).
// Contents: FSM state encoding, WnR polarity, bytes per word,
//           and a helper that clamps configurable cycle counts to 1..7.
// ----------------------------------------------------------------------------
package turf_bus_pkg;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR    = 3'd1;
    localparam logic [2:0] ST_WDATA   = 3'd2;
    localparam logic [2:0] ST_TURN    = 3'd3;
    localparam logic [2:0] ST_RDATA   = 3'd4;
    localparam logic [2:0] ST_RECOVER = 3'd5;

    localparam logic WNR_WRITE = 1'b1;
    localparam logic WNR_READ  = 1'b0;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_BYTE      = 2'(BYTES_PER_WORD - 1);

    // Cycle counts live in 3-bit counters; zero would mean "no cycle",
    // which the bus timing cannot tolerate, so force the range to 1..7.
    function automatic int clamp_cycles(input int n);
        return (n < 1) ? 1 : ((n > 7) ? 7 : n);
    endfunction

endpackage

// File: rtl/turf_bus_initiator.sv
// ----------------------------------------------------------------------------
// turf_bus_initiator
// TURFIO-side master of the TURF register bus. Turns one local request
// (8-bit address, 32-bit data) into a byte-serial bus transaction:
// address byte, then 4 write bytes or a bus turnaround plus 4 read bytes,
// all LSB byte first, followed by a recovery gap with nCS high.
//
// Ports
//   clk_i, rst_i        bus clock, asynchronous active-high reset
//   req_i, wr_i,        request strobe and its write flag, address, data;
//   addr_i, wdata_i     sampled only while idle (busy_o=0)
//   busy_o, ack_o       busy through recovery; one-cycle completion strobe
//   rdata_o             last completed read word
//   turf_ncs_o          nCSTURF (active low)
//   turf_wnr_o          TURF_WnR (1 = write)
//   turf_dio_o/_oe_o    DIO output byte and its drive enable
//   turf_dio_i          DIO input byte from the pad
//
// state   | meaning
// IDLE    | bus released, waiting for req_i
// ADDR    | driving address byte, nCS low
// WDATA   | driving write bytes 0..3
// TURN    | DIO released, responder takes the bus
// RDATA   | sampling read bytes 0..3
// RECOVER | nCS high for IDLE_CYCLES, ack_o in first cycle
// ----------------------------------------------------------------------------
module turf_bus_initiator
    import turf_bus_pkg::*;
#(
    parameter int TURN_CYCLES = 1,
    parameter int IDLE_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        turf_ncs_o,
    output logic        turf_wnr_o,
    output logic [7:0]  turf_dio_o,
    output logic        turf_dio_oe_o,
    input  logic [7:0]  turf_dio_i
);

    // Counters are down-counters loaded with (cycles-1); exit on zero.
    localparam logic [2:0] TURN_LOAD = 3'(clamp_cycles(TURN_CYCLES) - 1);
    localparam logic [2:0] REC_LOAD  = 3'(clamp_cycles(IDLE_CYCLES) - 1);

    state_t      r_state;
    logic        r_wr;
    logic [31:0] r_wdata;
    logic [23:0] r_rshift;
    logic [1:0]  r_byte_cnt;
    logic [2:0]  r_turn_cnt;
    logic [2:0]  r_rec_cnt;

    logic        w_last_byte;
    assign w_last_byte = (r_byte_cnt == LAST_BYTE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_wr          <= WNR_READ;
            r_wdata       <= '0;
            r_rshift      <= '0;
            r_byte_cnt    <= '0;
            r_turn_cnt    <= '0;
            r_rec_cnt     <= '0;
            busy_o        <= 1'b0;
            ack_o         <= 1'b0;
            rdata_o       <= '0;
            turf_ncs_o    <= 1'b1;
            turf_wnr_o    <= WNR_READ;
            turf_dio_o    <= '0;
            turf_dio_oe_o <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_i) begin
                        r_wr          <= wr_i;
                        r_wdata       <= wdata_i;
                        busy_o        <= 1'b1;
                        turf_ncs_o    <= 1'b0;
                        turf_wnr_o    <= wr_i;
                        turf_dio_o    <= addr_i;
                        turf_dio_oe_o <= 1'b1;
                        r_state       <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    r_byte_cnt <= '0;
                    if (r_wr == WNR_WRITE) begin
                        turf_dio_o <= r_wdata[7:0];
                        r_state    <= ST_WDATA;
                    end else begin
                        turf_dio_oe_o <= 1'b0;
                        r_turn_cnt    <= TURN_LOAD;
                        r_state       <= ST_TURN;
                    end
                end
                ST_WDATA: begin
                    // Count wraps 3->0 on the last byte, ready for next time.
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    if (w_last_byte) begin
                        turf_ncs_o    <= 1'b1;
                        turf_dio_oe_o <= 1'b0;
                        turf_wnr_o    <= WNR_READ;
                        ack_o         <= 1'b1;
                        r_rec_cnt     <= REC_LOAD;
                        r_state       <= ST_RECOVER;
                    end else begin
                        // Next byte sits in [15:8]; shift keeps it there.
                        turf_dio_o <= r_wdata[15:8];
                        r_wdata    <= {8'h00, r_wdata[31:8]};
                    end
                end
                ST_TURN: begin
                    if (r_turn_cnt == 3'd0) begin
                        r_state <= ST_RDATA;
                    end else begin
                        r_turn_cnt <= r_turn_cnt - 3'd1;
                    end
                end
                ST_RDATA: begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    case (r_byte_cnt)
                        2'd0:    r_rshift[7:0]   <= turf_dio_i;
                        2'd1:    r_rshift[15:8]  <= turf_dio_i;
                        2'd2:    r_rshift[23:16] <= turf_dio_i;
                        default: rdata_o         <= {turf_dio_i, r_rshift};
                    endcase
                    if (w_last_byte) begin
                        turf_ncs_o <= 1'b1;
                        turf_wnr_o <= WNR_READ;
                        ack_o      <= 1'b1;
                        r_rec_cnt  <= REC_LOAD;
                        r_state    <= ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    if (r_rec_cnt == 3'd0) begin
                        busy_o  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_rec_cnt <= r_rec_cnt - 3'd1;
                    end
                end
                default: begin
                    busy_o        <= 1'b0;
                    turf_ncs_o    <= 1'b1;
                    turf_dio_oe_o <= 1'b0;
                    turf_wnr_o    <= WNR_READ;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
